key_debounce_capture: RTL and testbench

//  Conditions the four raw DE0-CV push-buttons (KEY[3:0], active-low) before they reach the

---
 rtl/key_debounce_capture_pkg.sv | 15 +
 rtl/key_debounce_capture_cell.sv | 50 +++++
 rtl/key_debounce_capture.sv | 45 ++++
 tb/tb_key_debounce_capture.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/key_debounce_capture_pkg.sv
// Shared constants and helpers for the push-button conditioning block.
// Key pins are active-low: a pressed key reads 0.
package key_pkg;

   localparam int DEFAULT_DEBOUNCE_CYCLES = 500000;

   localparam logic KEY_RELEASED = 1'b1;
   localparam logic KEY_PRESSED  = 1'b0;

   // The counter only ever reaches n-1, but n+1 keeps the width sane for n=1.
   function automatic int cnt_width(input int n);
      return $clog2(n + 1);
   endfunction

endpackage

// File: rtl/key_debounce_capture_cell.sv
// One key: two-flop synchroniser, stable-time counter, debounced level and
// single-cycle press/lift pulses on each accepted transition.
module key_debounce_cell
   import key_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
   input  logic clk,
   input  logic reset,
   input  logic key_raw,
   output logic level,
   output logic press,
   output logic lift
);

   localparam int CW = cnt_width(DEBOUNCE_CYCLES);
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

   logic          s1;
   logic          s2;
   logic [CW-1:0] cnt;

   always_ff @(posedge clk) begin
      if (reset) begin
         s1    <= KEY_RELEASED;
         s2    <= KEY_RELEASED;
         level <= KEY_RELEASED;
         cnt   <= '0;
         press <= 1'b0;
         lift  <= 1'b0;
      end else begin
         s1    <= key_raw;
         s2    <= s1;
         press <= 1'b0;
         lift  <= 1'b0;
         // Any return to the accepted level restarts the stable-time window.
         if (s2 == level) begin
            cnt <= '0;
         end else if (cnt == CNT_LAST) begin
            level <= s2;
            cnt   <= '0;
            press <= (s2 == KEY_PRESSED);
            lift  <= (s2 == KEY_RELEASED);
         end else begin
            cnt <= cnt + CW'(1);
         end
      end
   end

endmodule

// File: rtl/key_debounce_capture.sv
// Push-button conditioning between the board KEY pins and the key PIO:
// per-key debounce cells plus sticky press capture and a maskable interrupt.
module key_debounce_capture
   import key_pkg::*;
#(
   parameter int NUM_KEYS        = 4,
   parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
   input  logic                clk_clk,
   input  logic                reset_reset,
   input  logic [NUM_KEYS-1:0] key_in,
   output logic [NUM_KEYS-1:0] key_level,
   output logic [NUM_KEYS-1:0] key_press,
   output logic [NUM_KEYS-1:0] key_release,
   input  logic [NUM_KEYS-1:0] capture_clr,
   input  logic [NUM_KEYS-1:0] irq_mask,
   output logic [NUM_KEYS-1:0] edge_capture,
   output logic                irq
);

   for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
      key_debounce_cell #(
         .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_cell (
         .clk     (clk_clk),
         .reset   (reset_reset),
         .key_raw (key_in[i]),
         .level   (key_level[i]),
         .press   (key_press[i]),
         .lift    (key_release[i])
      );
   end

   // A press arriving in the same cycle as a clear wins so no press is lost.
   always_ff @(posedge clk_clk) begin
      if (reset_reset) begin
         edge_capture <= '0;
         irq          <= 1'b0;
      end else begin
         edge_capture <= (edge_capture & ~capture_clr) | key_press;
         irq          <= |(edge_capture & irq_mask);
      end
   end

endmodule

// File: tb/tb_key_debounce_capture.sv
// Directed bench with DEBOUNCE_CYCLES=4; expectations are queued with a due
// cycle when stimulus is driven and checked on the falling edge.
module tb_key_debounce_capture;

   localparam int LVL = 0;
   localparam int PRS = 1;
   localparam int REL = 2;
   localparam int CAP = 3;
   localparam int IRQ = 4;

   logic       clk_clk = 1'b0;
   logic       reset_reset;
   logic [3:0] key_in;
   logic [3:0] key_level;
   logic [3:0] key_press;
   logic [3:0] key_release;
   logic [3:0] capture_clr;
   logic [3:0] irq_mask;
   logic [3:0] edge_capture;
   logic       irq;

   typedef struct {
      int         due;
      int         sel;
      logic [3:0] mask;
      logic [3:0] val;
      string      tag;
   } exp_t;

   exp_t       sb[$];
   int         cyc = 0;
   int         vectors = 0;
   int         miscompares = 0;
   logic [3:0] obs;

   key_debounce_capture #(
      .NUM_KEYS        (4),
      .DEBOUNCE_CYCLES (4)
   ) dut (
      .clk_clk      (clk_clk),
      .reset_reset  (reset_reset),
      .key_in       (key_in),
      .key_level    (key_level),
      .key_press    (key_press),
      .key_release  (key_release),
      .capture_clr  (capture_clr),
      .irq_mask     (irq_mask),
      .edge_capture (edge_capture),
      .irq          (irq)
   );

   always #10 clk_clk = ~clk_clk;

   always @(posedge clk_clk) cyc <= cyc + 1;

   function automatic logic [3:0] pick(input int sel);
      case (sel)
         LVL:     return key_level;
         PRS:     return key_press;
         REL:     return key_release;
         CAP:     return edge_capture;
         default: return {3'b000, irq};
      endcase
   endfunction

   always @(negedge clk_clk) begin
      for (int i = sb.size() - 1; i >= 0; i--) begin
         if (sb[i].due == cyc) begin
            obs = pick(sb[i].sel) & sb[i].mask;
            vectors++;
            assert (obs === (sb[i].val & sb[i].mask)) else begin
               miscompares++;
               $error("FAIL %s cyc=%0d observed=%b expected=%b", sb[i].tag, cyc, obs,
                      sb[i].val & sb[i].mask);
            end
            sb.delete(i);
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk_clk);
      #1;
   endtask

   task automatic expect_at(input string tag, input int sel, input logic [3:0] mask,
                            input logic [3:0] val, input int off);
      sb.push_back('{cyc + off, sel, mask, val, tag});
   endtask

   task automatic expect_span(input string tag, input int sel, input logic [3:0] mask,
                              input logic [3:0] val, input int from, input int upto);
      for (int c = from; c <= upto; c++) expect_at(tag, sel, mask, val, c);
   endtask

   initial begin
      reset_reset = 1'b1;
      key_in      = 4'h0;
      irq_mask    = 4'h0;
      capture_clr = 4'h0;

      // Reset held three cycles with all raw keys low
      expect_span("rst_level",   LVL, 4'hF, 4'hF, 1, 3);
      expect_span("rst_press",   PRS, 4'hF, 4'h0, 1, 3);
      expect_span("rst_release", REL, 4'hF, 4'h0, 1, 3);
      expect_span("rst_capture", CAP, 4'hF, 4'h0, 1, 3);
      expect_span("rst_irq",     IRQ, 4'h1, 4'h0, 1, 3);
      tick(3);
      vectors++;
      if (key_level !== 4'hF) begin
         miscompares++;
         $error("FAIL direct rst key_level=%b", key_level);
      end
      vectors++;
      if (edge_capture !== 4'h0) begin
         miscompares++;
         $error("FAIL direct rst edge_capture=%b", edge_capture);
      end
      vectors++;
      if (irq !== 1'b0) begin
         miscompares++;
         $error("FAIL direct rst irq=%b", irq);
      end
      vectors++;
      if ((key_press | key_release) !== 4'h0) begin
         miscompares++;
         $error("FAIL direct rst pulses press=%b release=%b", key_press, key_release);
      end
      reset_reset = 1'b0;
      key_in      = 4'hF;
      expect_at("post_rst_level", LVL, 4'hF, 4'hF, 1);
      expect_at("post_rst_press", PRS, 4'hF, 4'h0, 1);
      expect_at("post_rst_rel",   REL, 4'hF, 4'h0, 1);
      expect_at("post_rst_cap",   CAP, 4'hF, 4'h0, 1);
      expect_at("post_rst_irq",   IRQ, 4'h1, 4'h0, 1);
      tick(3);

      // Clean press and release of key0
      key_in[0] = 1'b0;
      expect_span("k0_press_quiet", PRS, 4'h1, 4'h0, 1, 5);
      expect_at("k0_level_hold",  LVL, 4'h1, 4'h1, 5);
      expect_at("k0_level_press", LVL, 4'h1, 4'h0, 6);
      expect_at("k0_press_pulse", PRS, 4'h1, 4'h1, 6);
      expect_at("k0_press_end",   PRS, 4'h1, 4'h0, 7);
      expect_at("k0_cap_before",  CAP, 4'h1, 4'h0, 6);
      expect_at("k0_cap_set",     CAP, 4'h1, 4'h1, 7);
      expect_at("k0_irq_masked",  IRQ, 4'h1, 4'h0, 8);
      tick(10);
      vectors++;
      if (key_level[0] !== 1'b0) begin
         miscompares++;
         $error("FAIL direct k0 key_level[0]=%b", key_level[0]);
      end
      vectors++;
      if (edge_capture[0] !== 1'b1) begin
         miscompares++;
         $error("FAIL direct k0 edge_capture[0]=%b", edge_capture[0]);
      end
      key_in[0] = 1'b1;
      expect_at("k0_rel_quiet",   REL, 4'h1, 4'h0, 5);
      expect_at("k0_level_held",  LVL, 4'h1, 4'h0, 5);
      expect_at("k0_rel_pulse",   REL, 4'h1, 4'h1, 6);
      expect_at("k0_level_up",    LVL, 4'h1, 4'h1, 6);
      expect_at("k0_rel_no_prs",  PRS, 4'h1, 4'h0, 6);
      expect_at("k0_rel_end",     REL, 4'h1, 4'h0, 7);
      expect_at("k0_cap_sticky",  CAP, 4'h1, 4'h1, 7);
      tick(10);

      // Bouncing key1: 2-cycle segments, then held low from the last toggle
      expect_span("k1_bounce_quiet", PRS, 4'h2, 4'h0, 1, 13);
      expect_at("k1_bounce_level",   LVL, 4'h2, 4'h2, 13);
      expect_at("k1_bounce_press",   PRS, 4'h2, 4'h2, 14);
      expect_at("k1_bounce_lvl_dn",  LVL, 4'h2, 4'h0, 14);
      expect_at("k1_bounce_end",     PRS, 4'h2, 4'h0, 15);
      key_in[1] = 1'b0; tick(2);
      key_in[1] = 1'b1; tick(2);
      key_in[1] = 1'b0; tick(2);
      key_in[1] = 1'b1; tick(2);
      key_in[1] = 1'b0;
      tick(16);

      // Three-cycle glitch on the held key1 must be ignored
      expect_span("k1_glitch_rel", REL, 4'h2, 4'h0, 1, 12);
      expect_span("k1_glitch_lvl", LVL, 4'h2, 4'h0, 1, 12);
      key_in[1] = 1'b1; tick(3);
      key_in[1] = 1'b0;
      tick(12);

      // Interrupt on key2 with mask 0100
      irq_mask  = 4'b0100;
      key_in[2] = 1'b0;
      expect_at("k2_cap_before", CAP, 4'h4, 4'h0, 6);
      expect_at("k2_cap_set",    CAP, 4'h4, 4'h4, 7);
      expect_at("k2_irq_lag",    IRQ, 4'h1, 4'h0, 7);
      expect_at("k2_irq_set",    IRQ, 4'h1, 4'h1, 8);
      tick(10);
      vectors++;
      if (irq !== 1'b1) begin
         miscompares++;
         $error("FAIL direct k2 irq=%b", irq);
      end
      capture_clr = 4'b0100;
      expect_at("k2_cap_clr",    CAP, 4'h4, 4'h0, 1);
      expect_at("k2_cap_others", CAP, 4'h3, 4'h3, 1);
      expect_at("k2_irq_hold",   IRQ, 4'h1, 4'h1, 1);
      expect_at("k2_irq_clr",    IRQ, 4'h1, 4'h0, 2);
      tick(1);
      capture_clr = 4'b0000;
      tick(4);
      key_in[3] = 1'b0;
      expect_at("k3_cap_set",      CAP, 4'h8, 4'h8, 7);
      expect_span("k3_irq_masked", IRQ, 4'h1, 4'h0, 1, 10);
      tick(12);

      // Clear held across a key0 press: the press wins for one cycle
      capture_clr = 4'b0001;
      key_in[0]   = 1'b0;
      expect_span("col_cap_clr",  CAP, 4'h1, 4'h0, 1, 6);
      expect_at("col_press",      PRS, 4'h1, 4'h1, 6);
      expect_at("col_cap_win",    CAP, 4'h1, 4'h1, 7);
      expect_span("col_cap_gone", CAP, 4'h1, 4'h0, 8, 10);
      tick(10);
      capture_clr = 4'b0000;
      tick(2);

      // Reset while key3 press has counted to 2
      key_in[3] = 1'b1;
      tick(10);
      key_in[3] = 1'b0;
      expect_span("mid_rst_quiet", PRS, 4'h8, 4'h0, 1, 10);
      expect_at("mid_rst_nopulse", PRS, 4'hF, 4'h0, 5);
      expect_at("mid_rst_level",   LVL, 4'hF, 4'hF, 5);
      expect_at("mid_rst_cap",     CAP, 4'hF, 4'h0, 5);
      expect_at("mid_rst_irq",     IRQ, 4'h1, 4'h0, 5);
      tick(4);
      reset_reset = 1'b1;
      tick(1);
      reset_reset = 1'b0;
      expect_at("mid_rst_k3_lvl",   LVL, 4'h8, 4'h8, 5);
      expect_at("mid_rst_k3_press", PRS, 4'h8, 4'h8, 6);
      expect_at("mid_rst_k3_end",   PRS, 4'h8, 4'h0, 7);
      expect_at("mid_rst_k3_cap",   CAP, 4'h8, 4'h8, 7);
      tick(10);

      for (int i = 0; i < 50 && sb.size() != 0; i++) @(posedge clk_clk);
      while (sb.size() != 0) begin
         vectors++;
         miscompares++;
         $display("FAIL %s never checked (due cyc=%0d, now %0d)", sb[0].tag, sb[0].due, cyc);
         void'(sb.pop_front());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
